// File: rtl/arb_pkg.sv
// Shared types and constants for the unified memory-port arbiter.
package arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } arb_state_t;

  localparam logic [3:0]  FULL_MASK    = 4'hF;
  localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_timeout_counter.sv
// Watchdog counter for the arbiter: cleared while idle, counts cycles spent
// waiting on the memory, and flags expiry on the last allowed wait cycle.
// Only built when ARB_TIMEOUT_EN is defined.
`ifdef ARB_TIMEOUT_EN
module arb_timeout_counter
  import arb_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and saturate at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of wait cycles already completed, so the limit is
  // reached during the cycle in which cnt_q equals limit-1.
  assign expired_o = enable_i && ((limit_i == '0) || (cnt_q >= (limit_i - 1'b1)));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one memory port between instruction fetch and load/store.
// Data requests have fixed priority; one access is in flight at a time and
// every output is registered. Optional watchdog: define ARB_TIMEOUT_EN.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_mask,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_mask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  arb_state_t        state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [3:0]        mem_mask_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_valid_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              d_valid_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              busy_q;
  logic              err_q;
  logic              tmo_expired;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic tmo_clear;
  logic tmo_enable;

  assign tmo_clear  = (state_q == IDLE);
  assign tmo_enable = (state_q == BUSY_I) || (state_q == BUSY_D);

  arb_timeout_counter #(
    .CNT_W (CNT_W)
  ) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (tmo_clear),
    .enable_i  (tmo_enable),
    .limit_i   (TMO_LIMIT),
    .expired_o (tmo_expired)
  );
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign tmo_expired        = 1'b0;
`endif

  // Arbitration FSM with all requester- and memory-side outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_mask_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      // Completion and error strobes are single-cycle pulses.
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (d_req) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_mask_q  <= d_mask;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            busy_q      <= 1'b1;
            state_q     <= BUSY_D;
          end else if (if_req) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_mask_q  <= FULL_MASK;
            mem_addr_q  <= if_addr;
            busy_q      <= 1'b1;
            state_q     <= BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          // A real response in the expiry cycle takes precedence over the error.
          if (mem_valid || tmo_expired) begin
            mem_req_q <= 1'b0;
            err_q     <= !mem_valid;
            if (state_q == BUSY_D) begin
              d_rdata_q <= mem_valid ? mem_rdata : DATA_W'(ARB_ERR_DATA);
              d_valid_q <= 1'b1;
              state_q   <= RESP_D;
            end else begin
              if_rdata_q <= mem_valid ? mem_rdata : DATA_W'(ARB_ERR_DATA);
              if_valid_q <= 1'b1;
              state_q    <= RESP_I;
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_mask  = mem_mask_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule
